// File: rtl/tx_arbiter_pkg.sv
// Shared types for the UART TX arbiter: FSM states, requester indices, GRANT codes.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package tx_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_SEND      = 2'd1,
        ST_WAIT_BUSY = 2'd2,
        ST_WAIT_DONE = 2'd3
    } state_t;

    localparam logic REQ0_IDX = 1'b0;
    localparam logic REQ1_IDX = 1'b1;

    localparam logic [1:0] GRANT_NONE = 2'b00;
    localparam logic [1:0] GRANT_REQ0 = 2'b01;
    localparam logic [1:0] GRANT_REQ1 = 2'b10;

    // One-hot GRANT code for a requester index
    function automatic logic [1:0] grant_onehot(input logic idx);
        return (idx == REQ1_IDX) ? GRANT_REQ1 : GRANT_REQ0;
    endfunction

endpackage

// File: rtl/tx_arbiter_rr_arb2.sv
// Two-way round-robin chooser: combinational pick from the VLDs, registered fairness pointer.
// Latency: grant is combinational; pointer moves on the edge after an upd_vld strobe.
// Backpressure: none; the caller decides when a pick is consumed and when to move the pointer.
module rr_arb2
    import tx_arbiter_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic req0_vld,
    input  logic req1_vld,
    input  logic upd_vld,
    input  logic upd_idx,
    output logic any_vld,
    output logic grant_idx
);

    // ptr_q holds the index favoured on a tie; reset favours REQ0
    logic ptr_q;
    logic ptr_d;

    // Pick the lone requester, or the favoured one when both are pending
    always_comb begin
        any_vld   = req0_vld | req1_vld;
        grant_idx = (req0_vld && req1_vld) ? ptr_q : req1_vld;
        ptr_d     = upd_vld ? ~upd_idx : ptr_q;
    end

    // After a frame ends (done or abort) favour the requester that was not served
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= REQ0_IDX;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/tx_arbiter.sv
// Shares one UART transmitter between an 8-bit and a 16-bit (LSB first) requester.
// Latency: ACK one cycle after capture, first strobe one cycle after ACK when TX is idle.
// Backpressure: holds each byte until TX_BUSY is low; aborts the frame if TX never goes busy.
module tx_arbiter
    import tx_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int BUSY_TIMEOUT = 4
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    REQ0_VLD,
    input  logic [DATA_WIDTH-1:0]   REQ0_DATA,
    output logic                    REQ0_ACK,
    input  logic                    REQ1_VLD,
    input  logic [2*DATA_WIDTH-1:0] REQ1_DATA,
    output logic                    REQ1_ACK,
    input  logic                    TX_BUSY,
    output logic [DATA_WIDTH-1:0]   TX_P_DATA,
    output logic                    TX_DATA_VALID,
    output logic [1:0]              GRANT,
    output logic                    ARB_BUSY,
    output logic                    TX_ERR
);

    localparam int               CNT_W     = $clog2(BUSY_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(BUSY_TIMEOUT);

    state_t                  state_q, state_d;
    logic [2*DATA_WIDTH-1:0] hold_q, hold_d;
    logic [1:0]              left_q, left_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [CNT_W-1:0]        cnt_inc;
    logic [1:0]              grant_q, grant_d;
    logic                    gidx_q, gidx_d;
    logic                    ack0_q, ack0_d;
    logic                    ack1_q, ack1_d;
    logic [DATA_WIDTH-1:0]   txd_q, txd_d;
    logic                    txv_q, txv_d;
    logic                    err_q, err_d;
    logic                    any_vld;
    logic                    arb_idx;
    logic                    upd_vld;

    rr_arb2 u_rr (
        .clk       (CLK),
        .rst_n     (RST),
        .req0_vld  (REQ0_VLD),
        .req1_vld  (REQ1_VLD),
        .upd_vld   (upd_vld),
        .upd_idx   (gidx_q),
        .any_vld   (any_vld),
        .grant_idx (arb_idx)
    );

    assign cnt_inc = cnt_q + 1'b1;

    // Frame sequencer: capture in IDLE, one strobe per byte, wait for TX busy rise then fall
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        left_d  = left_q;
        cnt_d   = cnt_q;
        grant_d = grant_q;
        gidx_d  = gidx_q;
        txd_d   = txd_q;
        ack0_d  = 1'b0;
        ack1_d  = 1'b0;
        txv_d   = 1'b0;
        err_d   = 1'b0;
        upd_vld = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // VLDs are only looked at here, so a held request is never captured twice
                if (any_vld) begin
                    gidx_d  = arb_idx;
                    hold_d  = (arb_idx == REQ1_IDX) ? REQ1_DATA
                                                    : {{DATA_WIDTH{1'b0}}, REQ0_DATA};
                    left_d  = (arb_idx == REQ1_IDX) ? 2'd2 : 2'd1;
                    grant_d = grant_onehot(arb_idx);
                    ack0_d  = (arb_idx == REQ0_IDX);
                    ack1_d  = (arb_idx == REQ1_IDX);
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                // A busy TX here still belongs to an earlier frame; wait it out
                if (!TX_BUSY) begin
                    txd_d   = hold_q[DATA_WIDTH-1:0];
                    txv_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_WAIT_BUSY;
                end
            end
            ST_WAIT_BUSY: begin
                if (TX_BUSY) begin
                    state_d = ST_WAIT_DONE;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == CNT_LIMIT) begin
                        err_d   = 1'b1;
                        left_d  = 2'd0;
                        grant_d = GRANT_NONE;
                        upd_vld = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_WAIT_DONE: begin
                if (!TX_BUSY) begin
                    left_d = left_q - 2'd1;
                    if (left_q != 2'd1) begin
                        hold_d  = hold_q >> DATA_WIDTH;
                        state_d = ST_SEND;
                    end else begin
                        grant_d = GRANT_NONE;
                        upd_vld = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, datapath and registered outputs; reset drops any partial frame
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= ST_IDLE;
            hold_q  <= '0;
            left_q  <= '0;
            cnt_q   <= '0;
            grant_q <= GRANT_NONE;
            gidx_q  <= REQ0_IDX;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            txd_q   <= '0;
            txv_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            left_q  <= left_d;
            cnt_q   <= cnt_d;
            grant_q <= grant_d;
            gidx_q  <= gidx_d;
            ack0_q  <= ack0_d;
            ack1_q  <= ack1_d;
            txd_q   <= txd_d;
            txv_q   <= txv_d;
            err_q   <= err_d;
        end
    end

    assign REQ0_ACK      = ack0_q;
    assign REQ1_ACK      = ack1_q;
    assign TX_P_DATA     = txd_q;
    assign TX_DATA_VALID = txv_q;
    assign GRANT         = grant_q;
    assign ARB_BUSY      = (state_q != ST_IDLE);
    assign TX_ERR        = err_q;

endmodule
